alu_share_sched: RTL and testbench
==================================

// Module: alu_share_sched
// PURPOSE
//  Shares one 4-bit ALU (AND/OR/ADD/SUB plus carry and overflow flags) between two requesters.
//  Round-robin arbitration; one transaction in flight at a time.
//  Each transaction: accept operands, drive the ALU for ALU_LAT cycles, capture Y/carry/overflow,
//  then return them on a valid/ready response port. Keeps a sticky overflow status bit.
//  Sits between the lab control logic and the combinational ALU/overflow datapath.
// PARAMETERS
//  WIDTH    4   operand/result width
//  ALU_LAT  1   cycles the ALU is driven before its outputs are sampled (>=1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 operation accepted this cycle
//  req0_op      in   2      00 AND, 01 OR, 10 ADD, 11 SUB
//  req0_a       in   WIDTH  operand A
//  req0_b       in   WIDTH  operand B
//  req1_*       same set for requester 1
//  alu_op       out  2      opcode to ALU (registered)
//  alu_a        out  WIDTH  operand A to ALU (registered)
//  alu_b        out  WIDTH  operand B to ALU (registered)
//  alu_y        in   WIDTH  ALU result
//  alu_cout     in   1      ALU carry out
//  alu_ovf      in   1      ALU signed overflow
//  rsp_valid    out  1      response available
//  rsp_ready    in   1      consumer takes response
//  rsp_id       out  1      requester that issued the response
//  rsp_y        out  WIDTH  captured result
//  rsp_cout     out  1      captured carry
//  rsp_ovf      out  1      captured overflow
//  sticky_ovf   out  1      set by any captured overflow, held until cleared
//  clr_sticky   in   1      clears sticky_ovf
// BEHAVIOUR
//  Reset: state IDLE; every output reg is 0 (alu_op/a/b, rsp_*, sticky_ovf); last_grant=1.
//    req*_ready is 0 during the reset cycle.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//    - reqN_ready = (state==IDLE) & grant==N. Combinational from reqN_valid and last_grant.
//    - Only one valid: that requester is granted.
//    - Both valid: the requester != last_grant is granted.
//    - On accept: latch op/a/b into alu_*, store id, update last_grant, load cnt=ALU_LAT-1, go EXEC.
//  EXEC:
//    - alu_* held stable.
//    - cnt>0: decrement.
//    - cnt==0: capture alu_y/cout/ovf into rsp_*, go RESP.
//  RESP:
//    - rsp_valid=1; rsp_* held stable until rsp_ready.
//    - rsp_valid & rsp_ready: go IDLE. No new accept in that same cycle.
//  Latency: accept at edge T -> rsp_valid high from cycle T+1+ALU_LAT.
//    Minimum request-to-request spacing is ALU_LAT+2 cycles.
//  sticky_ovf:
//    - Set on the capture edge when alu_ovf=1.
//    - clr_sticky clears it.
//    - Set and clear on the same edge: set wins.
//  rsp_valid is never asserted unless a capture has occurred. No response is ever duplicated or dropped.
//  Requesters hold valid/op/a/b stable until ready. A deasserted valid before ready is legal;
//    nothing is accepted.
//  Reset mid-EXEC or mid-RESP: the transaction is discarded, FSM goes to IDLE, rsp_valid=0
//    the next cycle. The requester re-issues.
//  The block does no arithmetic: flags come from the ALU unchanged; widths pass straight through.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams OP_AND/OP_OR/OP_ADD/OP_SUB (2 bits), FSM state encoding.
//  Sub-module rr_arb2: 2-way round-robin grant. Inputs valid[1:0], last_grant; output grant onehot.
//  FSM, latency counter, sticky bit and output regs stay in the top.
// TESTING
//  1 Reset release, no requests -> all outputs 0, state IDLE, ready 0 for both requesters.
//  2 req0 ADD a=4'b0111 b=4'b0001, ALU model returns y=1000 ovf=1 cout=0, ALU_LAT=1 ->
//    rsp_valid at T+2, rsp_id=0, rsp_y=1000, rsp_ovf=1, sticky_ovf=1.
//  3 req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 (first grant 0);
//    4 responses carry matching ids.
//  4 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both req*_ready stay 0,
//    rsp_ready=1 -> IDLE next cycle.
//  5 clr_sticky=1 on the same edge as a capture with ovf=1 -> sticky_ovf=1.
//    clr_sticky on a later cycle -> 0.
//  6 rst during EXEC with ALU_LAT=3 -> no rsp_valid afterwards, outputs 0.
//    Next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU scheduler.
//   OP_*    : 2-bit ALU opcodes as seen on req*_op / alu_op
//   state_t : scheduler FSM state encoding
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   valid[1:0]  in  requesters with a pending operation
//   last_grant  in  requester granted most recently
//   grant[1:0]  out one-hot grant (all zero when nothing is valid)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      // contention: hand the ALU to whoever did not get it last time
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// alu_share_sched: time-shares one combinational ALU between two requesters.
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid/ready     request handshake, op/a/b held by requester until ready
//   alu_op/a/b               registered drive to the external ALU
//   alu_y/cout/ovf           ALU outputs, sampled ALU_LAT cycles after accept
//   rsp_valid/ready          response handshake, rsp_id/y/cout/ovf held while valid
//   sticky_ovf, clr_sticky   overflow history bit and its clear
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no transaction; arbiter may accept one request
// ST_EXEC | ALU driven, cnt counts down to the sampling cycle
// ST_RESP | result captured, waiting for rsp_ready
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t           state;
  logic             last_grant;
  logic             cur_id;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             accept;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // ready is suppressed while rst is high so nothing looks accepted on the reset edge
  assign accept     = (state == ST_IDLE) && !rst && (grant != 2'b00);
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= '0;
      alu_op     <= 2'b00;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      // a capture later in this block overrides the clear (set wins)
      if (clr_sticky) sticky_ovf <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op     <= grant[1] ? req1_op : req0_op;
            alu_a      <= grant[1] ? req1_a  : req0_a;
            alu_b      <= grant[1] ? req1_b  : req0_b;
            cur_id     <= grant[1];
            last_grant <= grant[1];
            cnt        <= CNT_W'(ALU_LAT - 1);
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_y     <= alu_y;
            rsp_cout  <= alu_cout;
            rsp_ovf   <= alu_ovf;
            if (alu_ovf) sticky_ovf <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: two scheduler instances (ALU_LAT=1 and ALU_LAT=3), each driving
// its own behavioural ALU. A transaction-level model predicts grants, response
// timing/content and the sticky bit from the operands and arithmetic alone.
module tb_alu_share_sched;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[2];
  logic       r0v_s[2], r1v_s[2], rdy0[2], rdy1[2];
  logic [1:0] r0op_s[2], r1op_s[2], aop[2];
  logic [3:0] r0a_s[2], r0b_s[2], r1a_s[2], r1b_s[2];
  logic [3:0] aa[2], ab[2], ay[2], ry[2];
  logic       ac[2], ao[2], rv[2], rr_s[2], rid[2], rc[2], ro[2], stk_o[2], clr_s[2];

  function automatic logic [5:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] y;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    s = 5'd0;
    case (op)
      2'b00: y = a & b;
      2'b01: y = a | b;
      2'b10: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (y[3] != a[3]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        y = s[3:0];
        c = s[4];
        v = (a[3] != b[3]) && (y[3] != a[3]);
      end
    endcase
    return {c, v, y};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_share_sched #(.WIDTH(4), .ALU_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .rst        (rst_s[g]),
      .req0_valid (r0v_s[g]),
      .req0_ready (rdy0[g]),
      .req0_op    (r0op_s[g]),
      .req0_a     (r0a_s[g]),
      .req0_b     (r0b_s[g]),
      .req1_valid (r1v_s[g]),
      .req1_ready (rdy1[g]),
      .req1_op    (r1op_s[g]),
      .req1_a     (r1a_s[g]),
      .req1_b     (r1b_s[g]),
      .alu_op     (aop[g]),
      .alu_a      (aa[g]),
      .alu_b      (ab[g]),
      .alu_y      (ay[g]),
      .alu_cout   (ac[g]),
      .alu_ovf    (ao[g]),
      .rsp_valid  (rv[g]),
      .rsp_ready  (rr_s[g]),
      .rsp_id     (rid[g]),
      .rsp_y      (ry[g]),
      .rsp_cout   (rc[g]),
      .rsp_ovf    (ro[g]),
      .sticky_ovf (stk_o[g]),
      .clr_sticky (clr_s[g])
    );
    assign {ac[g], ao[g], ay[g]} = alu_ref(aop[g], aa[g], ab[g]);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // requester-side stimulus
  bit         v[2];
  logic [1:0] qop[2];
  logic [3:0] qa[2], qb[2];
  bit         rr, clr;

  // transaction model
  bit         busy, lastg, stk, eid, ec, eo;
  int         age, acc;
  logic [1:0] eop;
  logic [3:0] ea, eb, ey;
  bit         rsp_log[$];
  int         grants[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic new_req(input int i);
    v[i]   = 1'b1;
    qop[i] = 2'($urandom_range(0, 3));
    qa[i]  = 4'($urandom_range(0, 15));
    qb[i]  = 4'($urandom_range(0, 15));
  endtask

  // one clock of instance d: drive, sample mid-low-phase, advance the model over the edge
  task automatic step(input int d);
    int g, lat;
    bit ev;
    lat = (d == 0) ? 1 : 3;
    r0v_s[d] = v[0]; r0op_s[d] = qop[0]; r0a_s[d] = qa[0]; r0b_s[d] = qb[0];
    r1v_s[d] = v[1]; r1op_s[d] = qop[1]; r1a_s[d] = qa[1]; r1b_s[d] = qb[1];
    rr_s[d] = rr; clr_s[d] = clr;
    #1;
    g = -1;
    if (!busy) begin
      if (v[0] && v[1]) g = lastg ? 0 : 1;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end
    chk("req0_ready", rdy0[d], g == 0);
    chk("req1_ready", rdy1[d], g == 1);
    ev = busy && (age >= lat);
    chk("rsp_valid", rv[d], ev);
    if (ev) begin
      chk("rsp_id", rid[d], eid);
      chk("rsp_y", ry[d], ey);
      chk("rsp_cout", rc[d], ec);
      chk("rsp_ovf", ro[d], eo);
    end
    if (busy) begin
      chk("alu_op", aop[d], eop);
      chk("alu_a", aa[d], ea);
      chk("alu_b", ab[d], eb);
    end
    chk("sticky_ovf", stk_o[d], stk);
    if (ev && rr) begin
      busy = 1'b0;
      rsp_log.push_back(eid);
    end
    if (clr) stk = 1'b0;
    if (busy) begin
      age++;
      if (age == lat && eo) stk = 1'b1;
    end
    acc = g;
    if (g >= 0) begin
      busy  = 1'b1;
      age   = 0;
      lastg = g[0];
      eid   = g[0];
      eop   = qop[g];
      ea    = qa[g];
      eb    = qb[g];
      {ec, eo, ey} = alu_ref(qop[g], qa[g], qb[g]);
      v[g]  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    rst_s[d] = 1'b1; r0v_s[d] = 1'b1; r1v_s[d] = 1'b1; rr_s[d] = 1'b0; clr_s[d] = 1'b0;
    #1;
    chk("rst_ready0", rdy0[d], 0);
    chk("rst_ready1", rdy1[d], 0);
    @(negedge clk);
    rst_s[d] = 1'b0; r0v_s[d] = 1'b0; r1v_s[d] = 1'b0;
    busy = 1'b0; age = 0; lastg = 1'b1; stk = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0; rr = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_zero(input int d);
    chk("z_alu_op", aop[d], 0);
    chk("z_alu_a", aa[d], 0);
    chk("z_alu_b", ab[d], 0);
    chk("z_rsp_valid", rv[d], 0);
    chk("z_rsp_id", rid[d], 0);
    chk("z_rsp_y", ry[d], 0);
    chk("z_rsp_cout", rc[d], 0);
    chk("z_rsp_ovf", ro[d], 0);
    chk("z_sticky", stk_o[d], 0);
  endtask

  task automatic wait_rsp(input int d, input string tag);
    int k;
    k = 0;
    while (rv[d] !== 1'b1 && k < 20) begin
      step(d);
      k++;
    end
    chk(tag, rv[d], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; r0v_s[d] = 1'b0; r1v_s[d] = 1'b0; rr_s[d] = 1'b0; clr_s[d] = 1'b0;
      r0op_s[d] = 2'b00; r1op_s[d] = 2'b00;
      r0a_s[d] = 4'h0; r0b_s[d] = 4'h0; r1a_s[d] = 4'h0; r1b_s[d] = 4'h0;
    end
    @(negedge clk);

    // 1: reset release, idle outputs
    do_reset(0);
    do_reset(1);
    chk_zero(0);
    chk_zero(1);
    step(0);
    step(0);

    // 2: 7+1 overflows; ALU_LAT=1 response two samples after the accept
    v[0] = 1'b1; qop[0] = OP_ADD; qa[0] = 4'b0111; qb[0] = 4'b0001;
    step(0);
    step(0);
    chk("t2_valid", rv[0], 1);
    chk("t2_id", rid[0], 0);
    chk("t2_y", ry[0], 4'b1000);
    chk("t2_ovf", ro[0], 1);
    chk("t2_cout", rc[0], 0);
    chk("t2_sticky", stk_o[0], 1);
    rr = 1'b1;
    step(0);

    // 3: both requesting continuously, grants alternate from 0
    do_reset(0);
    rsp_log.delete();
    grants.delete();
    rr = 1'b1;
    for (int k = 0; k < 40 && rsp_log.size() < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!v[i]) new_req(i);
      step(0);
      if (acc >= 0) grants.push_back(acc);
    end
    chk("t3_rsp_count", rsp_log.size(), 4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++) begin
      chk("t3_grant", grants[i], i % 2);
      chk("t3_rsp_id", rsp_log[i], i % 2);
    end

    // 4: stalled response, both still requesting
    do_reset(0);
    new_req(0);
    new_req(1);
    wait_rsp(0, "t4_rsp_seen");
    for (int i = 0; i < 2; i++) if (!v[i]) new_req(i);
    repeat (5) step(0);
    rr = 1'b1;
    step(0);
    step(0);
    chk("t4_next_accept", acc, 1);

    // 5: clear coinciding with an overflow capture, then a later clear
    do_reset(0);
    v[0] = 1'b1; qop[0] = OP_SUB; qa[0] = 4'b1000; qb[0] = 4'b0001;
    step(0);
    clr = 1'b1;
    step(0);
    clr = 1'b0;
    chk("t5_set_wins", stk_o[0], 1);
    step(0);
    clr = 1'b1;
    step(0);
    clr = 1'b0;
    chk("t5_cleared", stk_o[0], 0);
    rr = 1'b1;
    step(0);

    // 6: reset in the middle of EXEC with ALU_LAT=3
    do_reset(1);
    v[1] = 1'b1; qop[1] = OP_ADD; qa[1] = 4'b0110; qb[1] = 4'b0011;
    rr = 1'b1;
    step(1);
    step(1);
    do_reset(1);
    chk_zero(1);
    rr = 1'b1;
    repeat (5) step(1);
    v[1] = 1'b1; qop[1] = OP_OR; qa[1] = 4'b1010; qb[1] = 4'b0101;
    wait_rsp(1, "t6_rsp_seen");
    chk("t6_y", ry[1], 4'b1111);
    chk("t6_id", rid[1], 1);
    step(1);

    // randomized traffic on both latencies
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      repeat (400) begin
        for (int i = 0; i < 2; i++) begin
          if (!v[i]) begin
            if ($urandom_range(0, 2) == 0) new_req(i);
          end else if ($urandom_range(0, 7) == 0) begin
            v[i] = 1'b0;
          end
        end
        rr  = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 7) == 0);
        step(d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
